// File: rtl/aha_cgra_sif_arbiter_if.sv
// Bundle of both requester channels and the CGRA simple data port that the
// arbiter multiplexes between them.
interface aha_cgra_sif_arbiter_if;
   logic        req0_valid;
   logic        req0_write;
   logic [31:0] req0_addr;
   logic [7:0]  req0_wstrb;
   logic [63:0] req0_wdata;
   logic        req0_ready;
   logic [63:0] req0_rdata;
   logic        req0_rvalid;

   logic        req1_valid;
   logic        req1_write;
   logic [31:0] req1_addr;
   logic [7:0]  req1_wstrb;
   logic [63:0] req1_wdata;
   logic        req1_ready;
   logic [63:0] req1_rdata;
   logic        req1_rvalid;

   logic [31:0] sif_wr_addr;
   logic [7:0]  sif_wr_en;
   logic [63:0] sif_wr_data;
   logic [31:0] sif_rd_addr;
   logic        sif_rd_en;
   logic [63:0] sif_rd_data;

   // Arbiter view: consumes requests, drives the CGRA port.
   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wstrb, req0_wdata,
      output req0_ready, req0_rdata, req0_rvalid,
      input  req1_valid, req1_write, req1_addr, req1_wstrb, req1_wdata,
      output req1_ready, req1_rdata, req1_rvalid,
      output sif_wr_addr, sif_wr_en, sif_wr_data, sif_rd_addr, sif_rd_en,
      input  sif_rd_data
   );

   // Environment view: requesters plus the CGRA data port itself.
   modport master (
      output req0_valid, req0_write, req0_addr, req0_wstrb, req0_wdata,
      input  req0_ready, req0_rdata, req0_rvalid,
      output req1_valid, req1_write, req1_addr, req1_wstrb, req1_wdata,
      input  req1_ready, req1_rdata, req1_rvalid,
      input  sif_wr_addr, sif_wr_en, sif_wr_data, sif_rd_addr, sif_rd_en,
      output sif_rd_data
   );
endinterface

// File: rtl/aha_cgra_sif_arbiter.sv
// Round-robin arbiter with bounded burst hold sharing the CGRA simple data
// port between two requesters; tracks the fixed-latency read and returns data.
module aha_cgra_sif_arbiter #(
   parameter int CGRA_RD_WS = 1,
   parameter int MAX_BURST  = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   aha_cgra_sif_arbiter_if.slave sif
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_RET
   } state_t;

   localparam logic [3:0] MAX_HOLD     = 4'(MAX_BURST);
   localparam logic [3:0] RD_WAIT_INIT = 4'(CGRA_RD_WS);

   state_t      state;
   logic        last_owner;
   logic        rd_owner;
   logic [3:0]  hold_cnt;
   logic [3:0]  wait_cnt;

   logic        grant_any;
   logic        grant1;
   logic        owner_keeps;
   logic        sel_write;
   logic [31:0] sel_addr;
   logic [7:0]  sel_wstrb;
   logic [63:0] sel_wdata;

   // hold_cnt==0 only right after reset, where nobody owns the port yet and
   // the round-robin pointer (last_owner=1) hands the first contest to req0.
   always_comb begin
      grant_any   = 1'b0;
      grant1      = 1'b0;
      owner_keeps = (hold_cnt != 4'd0) && (hold_cnt < MAX_HOLD);
      if (state == IDLE) begin
         if (sif.req0_valid && sif.req1_valid) begin
            grant_any = 1'b1;
            grant1    = owner_keeps ? last_owner : ~last_owner;
         end else if (sif.req0_valid) begin
            grant_any = 1'b1;
         end else if (sif.req1_valid) begin
            grant_any = 1'b1;
            grant1    = 1'b1;
         end
      end
   end

   assign sif.req0_ready = rst_n & grant_any & ~grant1;
   assign sif.req1_ready = rst_n & grant_any & grant1;

   assign sel_write = grant1 ? sif.req1_write : sif.req0_write;
   assign sel_addr  = grant1 ? sif.req1_addr  : sif.req0_addr;
   assign sel_wstrb = grant1 ? sif.req1_wstrb : sif.req0_wstrb;
   assign sel_wdata = grant1 ? sif.req1_wdata : sif.req0_wdata;

   // Strobes and pulses default low each cycle; addresses, write data and
   // read data registers hold their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_owner      <= 1'b1;
         rd_owner        <= 1'b0;
         hold_cnt        <= 4'd0;
         wait_cnt        <= 4'd0;
         sif.sif_wr_addr <= '0;
         sif.sif_wr_en   <= '0;
         sif.sif_wr_data <= '0;
         sif.sif_rd_addr <= '0;
         sif.sif_rd_en   <= 1'b0;
         sif.req0_rdata  <= '0;
         sif.req0_rvalid <= 1'b0;
         sif.req1_rdata  <= '0;
         sif.req1_rvalid <= 1'b0;
      end else begin
         sif.sif_wr_en   <= '0;
         sif.sif_rd_en   <= 1'b0;
         sif.req0_rvalid <= 1'b0;
         sif.req1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  if (grant1 != last_owner) begin
                     last_owner <= grant1;
                     hold_cnt   <= 4'd1;
                  end else if (hold_cnt < MAX_HOLD) begin
                     hold_cnt   <= hold_cnt + 4'd1;
                  end
                  if (sel_write) begin
                     sif.sif_wr_addr <= sel_addr;
                     sif.sif_wr_data <= sel_wdata;
                     sif.sif_wr_en   <= sel_wstrb;
                  end else begin
                     sif.sif_rd_addr <= sel_addr;
                     sif.sif_rd_en   <= 1'b1;
                     rd_owner        <= grant1;
                     wait_cnt        <= RD_WAIT_INIT;
                     state           <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= RD_RET;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RD_RET: begin
               // The CGRA data is valid during this cycle; capture it so the
               // owner sees RVALID with stable RDATA in the next IDLE cycle.
               if (rd_owner) begin
                  sif.req1_rdata  <= sif.sif_rd_data;
                  sif.req1_rvalid <= 1'b1;
               end else begin
                  sif.req0_rdata  <= sif.sif_rd_data;
                  sif.req0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aha_cgra_sif_arbiter.sv
// Scoreboard bench for aha_cgra_sif_arbiter: a grant model predicts READY each
// cycle and queues the expected CGRA writes and read returns.
module tb_aha_cgra_sif_arbiter;

   localparam int WS   = 1;
   localparam int MAXB = 4;

   typedef struct {
      int          due;
      logic [31:0] addr;
      logic [7:0]  en;
      logic [63:0] data;
   } wr_exp_t;

   typedef struct {
      int          due;
      bit          owner;
      logic [63:0] data;
   } rd_exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   tests = 0;
   int   failures = 0;

   aha_cgra_sif_arbiter_if sif ();

   aha_cgra_sif_arbiter #(
      .CGRA_RD_WS (WS),
      .MAX_BURST  (MAXB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // CGRA data port model: read data appears WS+1 cycles after the enable.
   logic        rd_v_pipe [0:WS];
   logic [31:0] rd_a_pipe [0:WS];

   function automatic logic [63:0] cgraData(input logic [31:0] a);
      if (a == 32'h40) return 64'hCAFE;
      return {~a, a ^ 32'h5A5A_0000};
   endfunction

   always @(posedge clk) begin
      rd_v_pipe[0] <= sif.sif_rd_en;
      rd_a_pipe[0] <= sif.sif_rd_addr;
      for (int i = 1; i <= WS; i++) begin
         rd_v_pipe[i] <= rd_v_pipe[i-1];
         rd_a_pipe[i] <= rd_a_pipe[i-1];
      end
   end

   assign sif.sif_rd_data = rd_v_pipe[WS] ? cgraData(rd_a_pipe[WS]) : 64'hDEAD_BEEF_DEAD_BEEF;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model and scoreboards, evaluated mid-cycle.
   wr_exp_t wq[$];
   rd_exp_t rq[$];
   int      acc_log[$];
   int      last_acc_cyc[2];
   int      last_rd_cyc = -1;
   bit      m_last = 1'b1;
   int      m_hold = 0;
   int      m_busy = -1;
   int      exp_rd_cyc = -1;
   logic [31:0] exp_rd_addr = '0;

   always @(negedge clk) begin
      bit      v0, v1, g0, g1, own, keep;
      wr_exp_t we;
      rd_exp_t re;
      if (!rst_n) begin
         m_last = 1'b1;
         m_hold = 0;
         m_busy = -1;
         exp_rd_cyc = -1;
         wq.delete();
         rq.delete();
      end else begin
         v0 = sif.req0_valid;
         v1 = sif.req1_valid;
         g0 = 1'b0;
         g1 = 1'b0;
         own = 1'b0;
         if (cyc > m_busy && (v0 || v1)) begin
            if (v0 && v1) begin
               keep = (m_hold != 0) && (m_hold < MAXB);
               own  = keep ? m_last : !m_last;
            end else begin
               own = v1;
            end
            g0 = !own;
            g1 = own;
         end
         checkOutput("req0_ready", sif.req0_ready, g0);
         checkOutput("req1_ready", sif.req1_ready, g1);

         if (wq.size() > 0 && wq[0].due == cyc) begin
            we = wq.pop_front();
            checkOutput("wr_en", sif.sif_wr_en, we.en);
            checkOutput("wr_addr", sif.sif_wr_addr, we.addr);
            checkOutput("wr_data", sif.sif_wr_data, we.data);
         end else begin
            checkOutput("wr_en_idle", sif.sif_wr_en, 0);
         end

         if (cyc == exp_rd_cyc) begin
            checkOutput("rd_en", sif.sif_rd_en, 1);
            checkOutput("rd_addr", sif.sif_rd_addr, exp_rd_addr);
         end else begin
            checkOutput("rd_en_idle", sif.sif_rd_en, 0);
         end

         if (rq.size() > 0 && rq[0].due == cyc) begin
            re = rq.pop_front();
            checkOutput("rvalid0", sif.req0_rvalid, !re.owner);
            checkOutput("rvalid1", sif.req1_rvalid, re.owner);
            if (re.owner) checkOutput("rdata1", sif.req1_rdata, re.data);
            else          checkOutput("rdata0", sif.req0_rdata, re.data);
         end else begin
            checkOutput("rvalid0_idle", sif.req0_rvalid, 0);
            checkOutput("rvalid1_idle", sif.req1_rvalid, 0);
         end

         if (g0 || g1) begin
            if (own != m_last) begin
               m_last = own;
               m_hold = 1;
            end else if (m_hold < MAXB) begin
               m_hold++;
            end
            acc_log.push_back(int'(own));
            last_acc_cyc[own] = cyc;
            if (own ? sif.req1_write : sif.req0_write) begin
               we.due  = cyc + 1;
               we.addr = own ? sif.req1_addr  : sif.req0_addr;
               we.en   = own ? sif.req1_wstrb : sif.req0_wstrb;
               we.data = own ? sif.req1_wdata : sif.req0_wdata;
               wq.push_back(we);
            end else begin
               re.due   = cyc + 3 + WS;
               re.owner = own;
               re.data  = cgraData(own ? sif.req1_addr : sif.req0_addr);
               rq.push_back(re);
               exp_rd_cyc  = cyc + 1;
               exp_rd_addr = own ? sif.req1_addr : sif.req0_addr;
               m_busy      = cyc + 2 + WS;
               last_rd_cyc = cyc;
            end
         end
      end
   end

   task automatic dropValid(input bit r);
      if (r) sif.req1_valid = 1'b0;
      else   sif.req0_valid = 1'b0;
   endtask

   // Presents one beat and returns one cycle after it is accepted, valid still high.
   task automatic applyStimulus(input bit r, input bit wr, input logic [31:0] a,
                                input logic [7:0] s, input logic [63:0] d);
      bit done = 1'b0;
      if (r) begin
         sif.req1_valid = 1'b1; sif.req1_write = wr; sif.req1_addr = a;
         sif.req1_wstrb = s;    sif.req1_wdata = d;
      end else begin
         sif.req0_valid = 1'b1; sif.req0_write = wr; sif.req0_addr = a;
         sif.req0_wstrb = s;    sif.req0_wdata = d;
      end
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (r ? (sif.req1_valid && sif.req1_ready) : (sif.req0_valid && sif.req0_ready))
            done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checkOutput("handshake_timeout", 0, 1);
         dropValid(r);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_ready0", sif.req0_ready, 0);
      checkOutput("rst_ready1", sif.req1_ready, 0);
      checkOutput("rst_rvalid0", sif.req0_rvalid, 0);
      checkOutput("rst_rvalid1", sif.req1_rvalid, 0);
      checkOutput("rst_rdata0", sif.req0_rdata, 0);
      checkOutput("rst_rdata1", sif.req1_rdata, 0);
      checkOutput("rst_wr_en", sif.sif_wr_en, 0);
      checkOutput("rst_wr_addr", sif.sif_wr_addr, 0);
      checkOutput("rst_wr_data", sif.sif_wr_data, 0);
      checkOutput("rst_rd_en", sif.sif_rd_en, 0);
      checkOutput("rst_rd_addr", sif.sif_rd_addr, 0);
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic stream(input bit r, input logic [31:0] base);
      for (int i = 0; i < 8; i++)
         applyStimulus(r, 1'b1, base + 32'(i * 8), 8'hFF, {base, 32'(i)});
      dropValid(r);
   endtask

   initial begin
      int pattern [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      rst_n = 1'b0;
      sif.req0_valid = 0; sif.req0_write = 0; sif.req0_addr = 0; sif.req0_wstrb = 0; sif.req0_wdata = 0;
      sif.req1_valid = 0; sif.req1_write = 0; sif.req1_addr = 0; sif.req1_wstrb = 0; sif.req1_wdata = 0;
      idleCycles(3);
      checkResetOutputs();
      rst_n = 1'b1;
      idleCycles(2);

      // Single req0 write.
      applyStimulus(0, 1, 32'h100, 8'hFF, 64'h1122_3344_5566_7788);
      dropValid(0);
      idleCycles(3);

      // req1 read of 0x40 returning 0xCAFE.
      applyStimulus(1, 0, 32'h40, 8'h00, 64'h0);
      dropValid(1);
      idleCycles(8);
      checkOutput("rdata1_hold", sif.req1_rdata, 64'hCAFE);

      // Both streaming writes: burst-limited alternation.
      resetDut();
      acc_log.delete();
      fork
         stream(0, 32'h1000);
         stream(1, 32'h2000);
      join
      idleCycles(3);
      checkOutput("stream_beats", acc_log.size(), 16);
      for (int i = 0; i < 9; i++)
         if (i < acc_log.size()) checkOutput("grant_pattern", acc_log[i], pattern[i]);

      // Read by req0 stalls a pending req1 write until the RVALID cycle.
      fork
         begin
            applyStimulus(0, 0, 32'h200, 8'h00, 64'h0);
            dropValid(0);
         end
         begin
            @(posedge clk);
            #1;
            applyStimulus(1, 1, 32'h300, 8'h0F, 64'hA5A5_5A5A_0F0F_F0F0);
            dropValid(1);
         end
      join
      checkOutput("wr_after_read", last_acc_cyc[1], last_rd_cyc + 3 + WS);
      idleCycles(4);

      // Reset while the read is in RD_WAIT; nothing may come back afterwards.
      applyStimulus(0, 0, 32'h80, 8'h00, 64'h0);
      dropValid(0);
      #2;
      sif.req1_valid = 1'b1;
      sif.req1_write = 1'b1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs();
      sif.req1_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(8);
      applyStimulus(0, 0, 32'h84, 8'h00, 64'h0);
      dropValid(0);
      idleCycles(8);

      // Zero-strobe writes still count toward req0's burst hold.
      resetDut();
      applyStimulus(0, 1, 32'h500, 8'hFF, 64'h11);
      applyStimulus(0, 1, 32'h504, 8'hFF, 64'h22);
      applyStimulus(0, 1, 32'h508, 8'hFF, 64'h33);
      applyStimulus(0, 1, 32'h50C, 8'h00, 64'h44);
      acc_log.delete();
      fork
         begin
            applyStimulus(0, 1, 32'h510, 8'hF0, 64'h55);
            dropValid(0);
         end
         begin
            applyStimulus(1, 1, 32'h600, 8'h0F, 64'h66);
            dropValid(1);
         end
      join
      checkOutput("wstrb0_hold_first", acc_log.size() > 0 ? acc_log[0] : -1, 1);
      checkOutput("wstrb0_hold_second", acc_log.size() > 1 ? acc_log[1] : -1, 0);
      idleCycles(5);

      checkOutput("wr_queue_drained", wq.size(), 0);
      checkOutput("rd_queue_drained", rq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
